// File: rtl/alu_mc_pkg.sv
// Shared definitions for the multi-cycle ALU: op codes, FSM states and flag bit positions.
package alu_mc_pkg;

    localparam int OP_W   = 5;
    localparam int FLAG_W = 5;

    typedef logic [OP_W-1:0] op_t;

    localparam op_t OP_ADD  = 5'd0;
    localparam op_t OP_SUB  = 5'd1;
    localparam op_t OP_MUL  = 5'd2;
    localparam op_t OP_DIV  = 5'd3;
    localparam op_t OP_MOD  = 5'd6;
    localparam op_t OP_MAX  = 5'd8;
    localparam op_t OP_MIN  = 5'd9;
    localparam op_t OP_PASS = 5'd15;
    localparam op_t OP_AND  = 5'd16;
    localparam op_t OP_OR   = 5'd17;
    localparam op_t OP_XOR  = 5'd18;
    localparam op_t OP_NOT  = 5'd19;
    localparam op_t OP_SHL  = 5'd24;
    localparam op_t OP_SHR  = 5'd25;
    localparam op_t OP_SRA  = 5'd26;
    localparam op_t OP_ROL  = 5'd27;
    localparam op_t OP_ROR  = 5'd28;

    // Flag vector layout is {dz, z, c, v, n}
    localparam int FLAG_N  = 0;
    localparam int FLAG_V  = 1;
    localparam int FLAG_C  = 2;
    localparam int FLAG_Z  = 3;
    localparam int FLAG_DZ = 4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CALC,
        ST_DONE
    } state_t;

    function automatic logic is_div_op(input op_t code);
        return (code == OP_DIV) || (code == OP_MOD);
    endfunction

endpackage

// File: rtl/alu_mc_muldiv.sv
// Iterative unit: shift-add multiplier or restoring divider, one operand bit per cycle.
// The *_nxt outputs carry the value of the iteration that completes on the edge where done is high.
module alu_mc_muldiv #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             div_mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] product_nxt,
    output logic [WIDTH-1:0] quotient_nxt,
    output logic [WIDTH-1:0] remainder_nxt
);
    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    logic             mode_q;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplier;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] divisor;
    logic [WIDTH-1:0] acc_nxt;
    logic [WIDTH-1:0] rem_nxt;
    logic [WIDTH-1:0] quo_nxt;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   trial;

    // A negative trial difference means the divisor did not fit: restore and shift in 0
    always_comb begin
        acc_nxt = mplier[0] ? (acc + mcand) : acc;
        shifted = {rem, quo[WIDTH-1]};
        trial   = shifted - {1'b0, divisor};
        rem_nxt = trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
        quo_nxt = {quo[WIDTH-2:0], ~trial[WIDTH]};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_q  <= 1'b0;
            cnt     <= '0;
            busy    <= 1'b0;
            acc     <= '0;
            mcand   <= '0;
            mplier  <= '0;
            rem     <= '0;
            quo     <= '0;
            divisor <= '0;
        end else if (start) begin
            mode_q  <= div_mode;
            cnt     <= '0;
            busy    <= 1'b1;
            acc     <= '0;
            mcand   <= a;
            mplier  <= b;
            rem     <= '0;
            quo     <= a;
            divisor <= b;
        end else if (busy) begin
            if (mode_q) begin
                rem <= rem_nxt;
                quo <= quo_nxt;
            end else begin
                acc    <= acc_nxt;
                mcand  <= mcand << 1;
                mplier <= mplier >> 1;
            end
            cnt <= cnt + 1'b1;
            if (cnt == LAST) begin
                busy <= 1'b0;
            end
        end
    end

    assign done          = busy && (cnt == LAST);
    assign product_nxt   = acc_nxt;
    assign quotient_nxt  = quo_nxt;
    assign remainder_nxt = rem_nxt;

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU with valid/ready handshakes on request and result sides.
// Define ALU_MC_ITER_EN to build the iterative MUL/DIV/MOD unit; without it those codes are illegal.
module alu_mc
    import alu_mc_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [OP_W-1:0]   op,
    input  logic [WIDTH-1:0]  a,
    input  logic [WIDTH-1:0]  b,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH-1:0]  result,
    output logic [FLAG_W-1:0] flags,
    output logic              illegal
);
    localparam int SH_W = $clog2(WIDTH);
    localparam logic [SH_W:0] WIDTH_SH = (SH_W + 1)'(WIDTH);

    state_t            state;
    logic [SH_W-1:0]   sh_amt;
    logic [SH_W:0]     inv_sh;
    logic [WIDTH:0]    add_full;
    logic [WIDTH:0]    sub_full;
    logic [WIDTH-1:0]  alu_res;
    logic              alu_c;
    logic              alu_v;
    logic              alu_dz;
    logic              alu_illegal;
    logic [FLAG_W-1:0] alu_flags;
    logic              iter_op;
    logic              calc_done;
    logic              calc_busy;
    logic [WIDTH-1:0]  calc_res;

    function automatic logic [FLAG_W-1:0] make_flags(input logic [WIDTH-1:0] r,
                                                     input logic dz, input logic c,
                                                     input logic v);
        logic [FLAG_W-1:0] f;
        f          = '0;
        f[FLAG_DZ] = dz;
        f[FLAG_Z]  = (r == '0);
        f[FLAG_C]  = c;
        f[FLAG_V]  = v;
        f[FLAG_N]  = r[WIDTH-1];
        return f;
    endfunction

    assign in_ready = (state == ST_IDLE);
    assign sh_amt   = b[SH_W-1:0];
    assign inv_sh   = WIDTH_SH - {1'b0, sh_amt};
    assign add_full = {1'b0, a} + {1'b0, b};
    assign sub_full = {1'b0, a} - {1'b0, b};

    // Single-cycle datapath; also supplies the divide-by-zero answers and the illegal decode
    always_comb begin
        alu_res     = '0;
        alu_c       = 1'b0;
        alu_v       = 1'b0;
        alu_dz      = 1'b0;
        alu_illegal = 1'b0;
        case (op)
            OP_ADD: begin
                alu_res = add_full[WIDTH-1:0];
                alu_c   = add_full[WIDTH];
                alu_v   = (a[WIDTH-1] == b[WIDTH-1]) && (add_full[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                alu_res = sub_full[WIDTH-1:0];
                alu_c   = sub_full[WIDTH];
                alu_v   = (a[WIDTH-1] != b[WIDTH-1]) && (sub_full[WIDTH-1] != a[WIDTH-1]);
            end
`ifdef ALU_MC_ITER_EN
            OP_MUL: begin
                alu_res = '0;
            end
            OP_DIV: begin
                alu_res = '1;
                alu_dz  = 1'b1;
            end
            OP_MOD: begin
                alu_dz = 1'b1;
            end
`endif
            OP_MAX:  alu_res = (a > b) ? a : b;
            OP_MIN:  alu_res = (a < b) ? a : b;
            OP_PASS: alu_res = a;
            OP_AND:  alu_res = a & b;
            OP_OR:   alu_res = a | b;
            OP_XOR:  alu_res = a ^ b;
            OP_NOT:  alu_res = ~a;
            OP_SHL:  alu_res = a << sh_amt;
            OP_SHR:  alu_res = a >> sh_amt;
            OP_SRA:  alu_res = $signed(a) >>> sh_amt;
            OP_ROL:  alu_res = (a << sh_amt) | (a >> inv_sh);
            OP_ROR:  alu_res = (a >> sh_amt) | (a << inv_sh);
            default: alu_illegal = 1'b1;
        endcase
        alu_flags = alu_illegal ? '0 : make_flags(alu_res, alu_dz, alu_c, alu_v);
    end

`ifdef ALU_MC_ITER_EN
    logic [OP_W-1:0]  op_q;
    logic             md_start;
    logic [WIDTH-1:0] md_product;
    logic [WIDTH-1:0] md_quotient;
    logic [WIDTH-1:0] md_remainder;

    assign iter_op  = (op == OP_MUL) || (is_div_op(op) && (b != '0));
    assign md_start = in_valid && in_ready && iter_op;
    assign calc_res = (op_q == OP_MUL) ? md_product :
                      (op_q == OP_DIV) ? md_quotient : md_remainder;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q <= OP_ADD;
        end else if (md_start) begin
            op_q <= op;
        end
    end

    alu_mc_muldiv #(
        .WIDTH(WIDTH)
    ) u_muldiv (
        .clk          (clk),
        .rst          (rst),
        .start        (md_start),
        .div_mode     (is_div_op(op)),
        .a            (a),
        .b            (b),
        .busy         (calc_busy),
        .done         (calc_done),
        .product_nxt  (md_product),
        .quotient_nxt (md_quotient),
        .remainder_nxt(md_remainder)
    );
`else
    assign iter_op   = 1'b0;
    assign calc_done = 1'b0;
    assign calc_busy = 1'b0;
    assign calc_res  = '0;
`endif

    // Single-cycle ops land in DONE on the accepting edge, which gives one op every two cycles
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            out_valid <= 1'b0;
            result    <= '0;
            flags     <= '0;
            illegal   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        if (iter_op) begin
                            state <= ST_CALC;
                        end else begin
                            state     <= ST_DONE;
                            out_valid <= 1'b1;
                            result    <= alu_res;
                            flags     <= alu_flags;
                            illegal   <= alu_illegal;
                        end
                    end
                end
                ST_CALC: begin
                    if (calc_done) begin
                        state     <= ST_DONE;
                        out_valid <= 1'b1;
                        result    <= calc_res;
                        flags     <= make_flags(calc_res, 1'b0, 1'b0, 1'b0);
                        illegal   <= 1'b0;
                    end else if (!calc_busy) begin
                        state <= ST_IDLE;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state     <= ST_IDLE;
                        out_valid <= 1'b0;
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_mc.sv
// Self-checking bench for alu_mc (WIDTH=32): directed vector table, hand-written corner
// sequences and randomized ops checked against an arithmetic reference model.
module tb_alu_mc;

`ifdef ALU_MC_ITER_EN
    localparam bit ITER = 1'b1;
`else
    localparam bit ITER = 1'b0;
`endif
    localparam int ITER_LAT = 33;
    localparam longint SMAX = 2147483647;
    localparam longint SMIN = -SMAX - 1;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic [4:0]  flags;
    logic        illegal;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       name;
        logic [4:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic [4:0]  fl;
        logic        ill;
        int          lat;
    } vec_t;

    vec_t vecs[$];

    alu_mc #(
        .WIDTH(32)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .op       (op),
        .a        (a),
        .b        (b),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .result   (result),
        .flags    (flags),
        .illegal  (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic compare(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Reference model written directly from the op definitions; flags are {dz, z, c, v, n}
    function automatic void refModel(input logic [4:0] m_op, input logic [31:0] m_a,
                                     input logic [31:0] m_b, output logic [31:0] m_res,
                                     output logic [4:0] m_fl, output logic m_ill,
                                     output int m_lat);
        longint unsigned ua, ub, wide;
        longint sa, sb, ssum;
        int s32, sh;
        logic c, v, dz;
        ua = m_a;
        ub = m_b;
        s32 = m_a;
        sa = s32;
        s32 = m_b;
        sb = s32;
        sh = int'(m_b[4:0]);
        c = 1'b0;
        v = 1'b0;
        dz = 1'b0;
        m_ill = 1'b0;
        m_lat = 1;
        m_res = '0;
        case (m_op)
            5'd0: begin
                wide = ua + ub;
                m_res = wide[31:0];
                c = wide[32];
                ssum = sa + sb;
                v = (ssum > SMAX) || (ssum < SMIN);
            end
            5'd1: begin
                m_res = m_a - m_b;
                c = (m_a < m_b);
                ssum = sa - sb;
                v = (ssum > SMAX) || (ssum < SMIN);
            end
            5'd2: begin
                if (ITER) begin
                    wide = ua * ub;
                    m_res = wide[31:0];
                    m_lat = ITER_LAT;
                end else m_ill = 1'b1;
            end
            5'd3, 5'd6: begin
                if (!ITER) m_ill = 1'b1;
                else if (m_b == 0) begin
                    dz = 1'b1;
                    m_res = (m_op == 5'd3) ? 32'hFFFF_FFFF : 32'h0;
                end else begin
                    m_res = (m_op == 5'd3) ? (m_a / m_b) : (m_a % m_b);
                    m_lat = ITER_LAT;
                end
            end
            5'd8:  m_res = (m_a > m_b) ? m_a : m_b;
            5'd9:  m_res = (m_a < m_b) ? m_a : m_b;
            5'd15: m_res = m_a;
            5'd16: m_res = m_a & m_b;
            5'd17: m_res = m_a | m_b;
            5'd18: m_res = m_a ^ m_b;
            5'd19: m_res = ~m_a;
            5'd24: m_res = m_a << sh;
            5'd25: m_res = m_a >> sh;
            5'd26: begin
                s32 = m_a;
                s32 = s32 >>> sh;
                m_res = s32;
            end
            5'd27: begin
                wide = (ua << sh) | (ua >> (32 - sh));
                m_res = wide[31:0];
            end
            5'd28: begin
                wide = (ua >> sh) | (ua << (32 - sh));
                m_res = wide[31:0];
            end
            default: m_ill = 1'b1;
        endcase
        if (m_ill) begin
            m_res = '0;
            m_fl = '0;
        end else begin
            m_fl = {dz, (m_res == 0), c, v, m_res[31]};
        end
    endfunction

    task automatic addVec(input string n, input logic [4:0] o, input logic [31:0] va,
                          input logic [31:0] vb, input logic [31:0] r, input logic [4:0] f,
                          input logic il, input int l);
        vec_t v;
        v.name = n;
        v.op = o;
        v.a = va;
        v.b = vb;
        v.res = r;
        v.fl = f;
        v.ill = il;
        v.lat = l;
        vecs.push_back(v);
    endtask

    // Entries whose answer only exists when the iterative unit is built
    task automatic addIterVec(input string n, input logic [4:0] o, input logic [31:0] va,
                              input logic [31:0] vb, input logic [31:0] r,
                              input logic [4:0] f, input int l);
        if (ITER) addVec(n, o, va, vb, r, f, 1'b0, l);
        else addVec(n, o, va, vb, 32'h0, 5'b0, 1'b1, 1);
    endtask

    // Issue one request, scramble the inputs after acceptance, count cycles to out_valid
    task automatic applyStimulus(input logic [4:0] t_op, input logic [31:0] t_a,
                                 input logic [31:0] t_b, input bit poke, output int t_lat);
        int waited;
        waited = 0;
        @(negedge clk);
        while (!in_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        compare("in_ready_wait", in_ready, 1);
        in_valid = 1'b1;
        op = t_op;
        a = t_a;
        b = t_b;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        op = 5'($urandom);
        a = $urandom;
        b = $urandom;
        t_lat = 1;
        while (!out_valid && t_lat < 100) begin
            if (poke) begin
                compare("busy_in_ready", in_ready, 0);
                in_valid = (t_lat % 3 == 1);
            end
            @(negedge clk);
            in_valid = 1'b0;
            t_lat++;
        end
    endtask

    task automatic checkOutput(input string name, input logic [31:0] e_res,
                               input logic [4:0] e_fl, input logic e_ill, input int e_lat,
                               input int got_lat, input int hold);
        compare({name, "_latency"}, got_lat, e_lat);
        compare({name, "_valid"}, out_valid, 1);
        compare({name, "_result"}, result, e_res);
        compare({name, "_flags"}, flags, e_fl);
        compare({name, "_illegal"}, illegal, e_ill);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            compare({name, "_hold_valid"}, out_valid, 1);
            compare({name, "_hold_result"}, result, e_res);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        compare({name, "_released"}, out_valid, 0);
    endtask

    initial begin
        int lat, accepts, dones, late_valid;
        logic [4:0] legal_ops[17];
        logic [4:0] r_op;
        logic [31:0] r_a, r_b, m_res;
        logic [4:0] m_fl;
        logic m_ill;
        int m_lat;

        legal_ops = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd6, 5'd8, 5'd9, 5'd15, 5'd16,
                      5'd17, 5'd18, 5'd19, 5'd24, 5'd25, 5'd26, 5'd27, 5'd28};

        addVec("add_carry", 5'd0, 32'hFFFF_FFFF, 32'h1, 32'h0, 5'b01100, 1'b0, 1);
        addVec("add_ovf", 5'd0, 32'h7FFF_FFFF, 32'h1, 32'h8000_0000, 5'b00011, 1'b0, 1);
        addVec("sub_ovf", 5'd1, 32'h8000_0000, 32'h1, 32'h7FFF_FFFF, 5'b00010, 1'b0, 1);
        addVec("sub_borrow", 5'd1, 32'h1, 32'h2, 32'hFFFF_FFFF, 5'b00101, 1'b0, 1);
        addVec("illegal_31", 5'd31, 32'h1234_5678, 32'h9, 32'h0, 5'b0, 1'b1, 1);
        addVec("illegal_4", 5'd4, 32'h1, 32'h1, 32'h0, 5'b0, 1'b1, 1);
        addVec("rol", 5'd27, 32'h8000_0001, 32'h1, 32'h0000_0003, 5'b0, 1'b0, 1);
        addVec("ror_upper_b", 5'd28, 32'h0000_0001, 32'h24, 32'h1000_0000, 5'b0, 1'b0, 1);
        addVec("shl", 5'd24, 32'h0000_00FF, 32'h108, 32'h0000_FF00, 5'b0, 1'b0, 1);
        addVec("max", 5'd8, 32'h5, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'b00001, 1'b0, 1);
        addVec("min", 5'd9, 32'h5, 32'hFFFF_FFFF, 32'h5, 5'b0, 1'b0, 1);
        addVec("not", 5'd19, 32'h0, 32'h0, 32'hFFFF_FFFF, 5'b00001, 1'b0, 1);
        addVec("xor_zero", 5'd18, 32'hA5A5_A5A5, 32'hA5A5_A5A5, 32'h0, 5'b01000, 1'b0, 1);
        addIterVec("div", 5'd3, 32'h100, 32'h7, 32'h24, 5'b0, ITER_LAT);
        addIterVec("mod", 5'd6, 32'h100, 32'h7, 32'h4, 5'b0, ITER_LAT);
        addIterVec("div_zero", 5'd3, 32'h100, 32'h0, 32'hFFFF_FFFF, 5'b10001, 1);
        addIterVec("mod_zero", 5'd6, 32'h100, 32'h0, 32'h0, 5'b11000, 1);
        addIterVec("mul", 5'd2, 32'h1_0000, 32'h1_0001, 32'h0001_0000, 5'b0, ITER_LAT);

        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        op = '0;
        a = '0;
        b = '0;
        #12;
        compare("reset_out_valid", out_valid, 0);
        compare("reset_result", result, 0);
        compare("reset_flags", flags, 0);
        compare("reset_illegal", illegal, 0);
        compare("reset_in_ready", in_ready, 1);
        @(negedge clk);
        rst = 1'b0;

        $display("[TB] directed vector table");
        foreach (vecs[i]) begin
            applyStimulus(vecs[i].op, vecs[i].a, vecs[i].b, 1'b0, lat);
            checkOutput(vecs[i].name, vecs[i].res, vecs[i].fl, vecs[i].ill, vecs[i].lat, lat, 0);
        end

        $display("[TB] held result while out_ready is low");
        applyStimulus(5'd26, 32'h8000_0000, 32'h4, 1'b0, lat);
        checkOutput("sra_hold", 32'hF800_0000, 5'b00001, 1'b0, 1, lat, 5);

        $display("[TB] requests while busy are ignored");
        addIterVec("mul_poke", 5'd2, 32'h1_0000, 32'h1_0001, 32'h0001_0000, 5'b0, ITER_LAT);
        applyStimulus(vecs[$].op, vecs[$].a, vecs[$].b, 1'b1, lat);
        checkOutput("mul_poke", vecs[$].res, vecs[$].fl, vecs[$].ill, vecs[$].lat, lat, 0);

        $display("[TB] back-to-back throughput");
        accepts = 0;
        dones = 0;
        @(negedge clk);
        in_valid = 1'b1;
        op = 5'd0;
        a = 32'h1;
        b = 32'h2;
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (in_ready) accepts++;
            if (out_valid) begin
                dones++;
                compare("tput_result", result, 32'h3);
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        out_ready = 1'b0;
        compare("tput_accepts", accepts, 3);
        compare("tput_dones", dones, 3);

        $display("[TB] reset in the middle of a divide");
        @(negedge clk);
        in_valid = 1'b1;
        op = 5'd3;
        a = 32'h100;
        b = 32'h7;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (10) @(negedge clk);
        #2 rst = 1'b1;
        #2;
        compare("midrst_valid", out_valid, 0);
        compare("midrst_result", result, 0);
        compare("midrst_in_ready", in_ready, 1);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        compare("postrst_in_ready", in_ready, 1);
        late_valid = 0;
        for (int i = 0; i < 40; i++) begin
            if (out_valid) late_valid++;
            @(negedge clk);
        end
        compare("postrst_no_valid", late_valid, 0);

        $display("[TB] randomized ops against reference model");
        for (int i = 0; i < 60; i++) begin
            int k;
            k = $urandom_range(0, 19);
            r_op = (k < 17) ? legal_ops[k] : 5'($urandom);
            r_a = $urandom;
            case ($urandom_range(0, 3))
                0: r_b = 32'h0;
                1: r_b = $urandom_range(1, 300);
                default: r_b = $urandom;
            endcase
            refModel(r_op, r_a, r_b, m_res, m_fl, m_ill, m_lat);
            applyStimulus(r_op, r_a, r_b, 1'($urandom_range(0, 1)), lat);
            checkOutput($sformatf("rand%0d_op%0d", i, r_op), m_res, m_fl, m_ill, m_lat, lat, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
